ball_sprite_renderer: RTL and testbench

Parametrised, pipelined sprite renderer for the game's balls. One instance draws any ball size from a single colour table by selecting a runtime power-of-two scale. A life-cycle state machine adds hidden, active and popping (flashing) behaviour in front of the colour lookup. It sits between the per-ball rectangle/position logic and the object-priority mux, producing `drawingRequest`/`RGBout` per pixel.

---
 rtl/ball_sprite_renderer.sv | 155 +++++++++++++++
 tb/tb_ball_sprite_renderer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_sprite_renderer.sv
// Ball sprite renderer: hidden/active/popping life cycle in front of a two-stage
// scaled colour-table lookup, producing one pixel per clock with 2-clock latency.
module ball_sprite_renderer #(
    parameter int         SPRITE_W    = 35,
    parameter int         SPRITE_H    = 35,
    parameter logic [7:0] TRANSPARENT = 8'hFF,
    parameter logic [7:0] POP_COLOR   = 8'hE0,
    parameter int         POP_FRAMES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        InsideRectangle,
    input  logic [1:0]  scale,
    input  logic        spawn,
    input  logic        hit,
    input  logic        frame_start,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [1:0]  state_out,
    output logic        pop_done
);

    localparam int         ROW_W    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int         COL_W    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam logic [7:0] POP_LAST = 8'(POP_FRAMES - 1);

    typedef enum logic [1:0] {
        HIDDEN  = 2'b00,
        ACTIVE  = 2'b01,
        POPPING = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    // Ball art: dark rim, body colour and a small highlight towards the top-left.
    function automatic logic [7:0] art_texel(input int r, input int c);
        int dx, dy, hx, hy, d2, rad2;
        dx   = 2 * c - (SPRITE_W - 1);
        dy   = 2 * r - (SPRITE_H - 1);
        hx   = dx + (SPRITE_W - 1) / 2;
        hy   = dy + (SPRITE_H - 1) / 2;
        d2   = dx * dx + dy * dy;
        rad2 = (SPRITE_W - 1) * (SPRITE_H - 1);
        if (d2 > rad2)
            return TRANSPARENT;
        else if (d2 * 4 > rad2 * 3)
            return 8'h0C;
        else if (hx * hx + hy * hy < rad2 / 16)
            return 8'hDB;
        else
            return 8'h1C;
    endfunction

    logic [7:0] sprite_rom [SPRITE_H][SPRITE_W];

    for (genvar r = 0; r < SPRITE_H; r++) begin : g_row
        for (genvar c = 0; c < SPRITE_W; c++) begin : g_col
            assign sprite_rom[r][c] = art_texel(r, c);
        end
    end

    state_t     state;
    logic [7:0] pop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HIDDEN;
            pop_cnt  <= 8'd0;
            pop_done <= 1'b0;
        end else begin
            pop_done <= 1'b0;
            case (state)
                HIDDEN: begin
                    if (spawn)
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    if (hit) begin
                        state   <= POPPING;
                        pop_cnt <= 8'd0;
                    end
                end
                POPPING: begin
                    if (frame_start) begin
                        if (pop_cnt == POP_LAST) begin
                            state    <= HIDDEN;
                            pop_done <= 1'b1;
                        end else begin
                            pop_cnt <= pop_cnt + 8'd1;
                        end
                    end
                end
                default: state <= HIDDEN;
            endcase
        end
    end

    assign state_out = state;

    logic [10:0] row_full;
    logic [10:0] col_full;
    logic        in_range;

    always_comb begin
        row_full = offsetY >> scale;
        col_full = offsetX >> scale;
        in_range = InsideRectangle
                && (row_full < 11'(SPRITE_H))
                && (col_full < 11'(SPRITE_W));
    end

    logic [ROW_W-1:0] row_s1;
    logic [COL_W-1:0] col_s1;
    logic             valid_s1;
    state_t           state_s1;
    logic             flash_off_s1;

    // Invalid pixels park the indices at 0 so the table is never addressed out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1       <= '0;
            col_s1       <= '0;
            valid_s1     <= 1'b0;
            state_s1     <= HIDDEN;
            flash_off_s1 <= 1'b0;
        end else begin
            row_s1       <= in_range ? row_full[ROW_W-1:0] : '0;
            col_s1       <= in_range ? col_full[COL_W-1:0] : '0;
            valid_s1     <= in_range;
            state_s1     <= state;
            flash_off_s1 <= pop_cnt[0];
        end
    end

    logic [7:0] texel;
    assign texel = sprite_rom[row_s1][col_s1];

    always_ff @(posedge clk) begin
        if (reset) begin
            RGBout <= TRANSPARENT;
        end else if (!valid_s1) begin
            RGBout <= TRANSPARENT;
        end else begin
            case (state_s1)
                ACTIVE:  RGBout <= texel;
                POPPING: RGBout <= (texel == TRANSPARENT || flash_off_s1) ? TRANSPARENT : POP_COLOR;
                default: RGBout <= TRANSPARENT;
            endcase
        end
    end

    assign drawingRequest = (RGBout != TRANSPARENT);

endmodule

// File: tb/tb_ball_sprite_renderer.sv
// Scoreboard bench for ball_sprite_renderer: a reference model predicts each pixel
// and the life-cycle state, and the monitor compares pixels 2 clocks after issue.
module tb_ball_sprite_renderer;

    localparam int POP_FRAMES = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] offsetX, offsetY;
    logic        InsideRectangle;
    logic [1:0]  scale;
    logic        spawn, hit, frame_start;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [1:0]  state_out;
    logic        pop_done;

    ball_sprite_renderer #(
        .SPRITE_W(35), .SPRITE_H(35), .TRANSPARENT(8'hFF),
        .POP_COLOR(8'hE0), .POP_FRAMES(POP_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .scale(scale), .spawn(spawn),
        .hit(hit), .frame_start(frame_start), .drawingRequest(drawingRequest),
        .RGBout(RGBout), .state_out(state_out), .pop_done(pop_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rgb;
        int         due;
        int         x;
        int         y;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [1:0] m_state;
    int         m_cnt;
    logic       m_done;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ball art: circle of radius 17 texels centred on texel (17,17).
    function automatic logic [7:0] ref_texel(input int r, input int c);
        int d;
        d = (r - 17) * (r - 17) + (c - 17) * (c - 17);
        if (d > 289)                                          return 8'hFF;
        if (d >= 217)                                         return 8'h0C;
        if ((2*c - 17) * (2*c - 17) + (2*r - 17) * (2*r - 17) < 72) return 8'hDB;
        return 8'h1C;
    endfunction

    function automatic logic [7:0] model_pixel(input int x, input int y,
                                               input logic ins, input logic [1:0] sc);
        int r, c;
        logic [7:0] t;
        r = y >> sc;
        c = x >> sc;
        if (!ins || r >= 35 || c >= 35 || m_state == 2'b00) return 8'hFF;
        t = ref_texel(r, c);
        if (m_state == 2'b01) return t;
        if (t == 8'hFF || m_cnt[0]) return 8'hFF;
        return 8'hE0;
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (mon_e.due != cyc) begin
                n_err++;
                $display("[TB] FAIL pixel_timing (%0d,%0d): checked at cycle %0d, due %0d", mon_e.x, mon_e.y, cyc, mon_e.due);
            end else begin
                if (RGBout !== mon_e.rgb) begin
                    n_err++;
                    $display("[TB] FAIL rgb (%0d,%0d): got %h expected %h", mon_e.x, mon_e.y, RGBout, mon_e.rgb);
                end
                n_cmp++;
                if (drawingRequest !== (mon_e.rgb != 8'hFF)) begin
                    n_err++;
                    $display("[TB] FAIL drawingRequest (%0d,%0d): got %b expected %b", mon_e.x, mon_e.y, drawingRequest, mon_e.rgb != 8'hFF);
                end
            end
        end
    end

    // One clock: drive a pixel and pulses, queue the prediction, advance the model, check state.
    task automatic step(input int x, input int y, input logic ins, input logic [1:0] sc,
                        input logic sp, input logic ht, input logic fs);
        exp_t ent;
        offsetX = 11'(x);
        offsetY = 11'(y);
        InsideRectangle = ins;
        scale = sc;
        spawn = sp;
        hit = ht;
        frame_start = fs;
        ent.rgb = model_pixel(x, y, ins, sc);
        ent.due = cyc + 2;
        ent.x = x;
        ent.y = y;
        sb.push_back(ent);
        m_done = 1'b0;
        case (m_state)
            2'b00: if (sp) m_state = 2'b01;
            2'b01: if (ht) begin m_state = 2'b10; m_cnt = 0; end
            2'b10: if (fs) begin
                if (m_cnt == POP_FRAMES - 1) begin m_state = 2'b00; m_done = 1'b1; end
                else m_cnt++;
            end
            default: m_state = 2'b00;
        endcase
        @(posedge clk);
        #1;
        spawn = 1'b0;
        hit = 1'b0;
        frame_start = 1'b0;
        n_cmp++;
        if (state_out !== m_state) begin
            n_err++;
            $display("[TB] FAIL state_out: got %b expected %b", state_out, m_state);
        end
        n_cmp++;
        if (pop_done !== m_done) begin
            n_err++;
            $display("[TB] FAIL pop_done: got %b expected %b", pop_done, m_done);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (RGBout !== 8'hFF || drawingRequest !== 1'b0 || state_out !== 2'b00 || pop_done !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL %s: got rgb=%h dr=%b st=%b pd=%b expected rgb=ff dr=0 st=00 pd=0",
                     name, RGBout, drawingRequest, state_out, pop_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        offsetX = '0; offsetY = '0; InsideRectangle = 1'b0; scale = 2'd0;
        spawn = 1'b0; hit = 1'b0; frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_state = 2'b00; m_cnt = 0; m_done = 1'b0;
        check_reset_outputs("reset_values");
    endtask

    task automatic test_active_sweep();
        step(0, 0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        for (int y = 0; y < 70; y++)
            for (int x = 0; x < 70; x++)
                step(x, y, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_out_of_range();
        step(40, 5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step(5, 40, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step(70, 34, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        step(34, 70, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        step(34, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step(17, 17, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(17, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step(279, 279, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        step(280, 0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pop();
        int pulses = 0;
        step(17, 17, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < POP_FRAMES; f++) begin
            for (int x = 0; x < 35; x++)
                step(x, 17, 1'b1, 2'd0, (f == 2 && x == 5), (f == 2 && x == 5), 1'b0);
            step(17, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
            if (pop_done === 1'b1) pulses++;
        end
        step(17, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (pulses != 1 || state_out !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL pop_sequence: got pulses=%0d state=%b expected pulses=1 state=00", pulses, state_out);
        end
    endtask

    task automatic test_hidden_pulses();
        step(17, 17, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        step(17, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step(17, 17, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
        step(17, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        step(3, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_pop();
        step(17, 17, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) begin
            step(17, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
            step(17, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        end
        step(17, 17, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        InsideRectangle = 1'b1;
        offsetX = 11'd17;
        offsetY = 11'd17;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_state = 2'b00; m_cnt = 0; m_done = 1'b0;
        check_reset_outputs("reset_mid_pop");
        for (int f = 0; f < 6; f++)
            step(17, 17, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 299), $urandom_range(0, 299), 1'b1, 2'(i % 4), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_active_sweep();
        test_out_of_range();
        test_pop();
        test_hidden_pulses();
        test_reset_mid_pop();
        test_back_to_back();
        InsideRectangle = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
